// File: rtl/alu_sequencer.sv
// Instruction-issue front end for the 4-bit ALU: accept, read operands, drive the
// ALU for one cycle, write back, then hold the response until it is taken.
module alu_sequencer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [13:0]  instr,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_opcode,
    output logic         alu_enable,
    input  logic [W-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_negative,
    input  logic         alu_carry,
    input  logic         alu_overflow,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [3:0]   res_flags,
    output logic         res_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] OP_LAST_ALU = 4'd10;
    localparam logic [3:0] OP_LDI      = 4'd11;
    localparam logic [3:0] OP_AND      = 4'd4;

    state_t       state_q, state_d;
    logic [3:0]   op_q, op_d;
    logic [1:0]   rd_q, rd_d;
    logic [W-1:0] imm_q, imm_d;
    logic [W-1:0] regs_q [4];
    logic [W-1:0] regs_d [4];
    logic [3:0]   flags_q, flags_d;
    logic         instr_ready_q, instr_ready_d;
    logic [W-1:0] alu_a_q, alu_a_d;
    logic [W-1:0] alu_b_q, alu_b_d;
    logic [3:0]   alu_opcode_q, alu_opcode_d;
    logic         alu_enable_q, alu_enable_d;
    logic         res_valid_q, res_valid_d;
    logic [W-1:0] res_data_q, res_data_d;
    logic [3:0]   res_flags_q, res_flags_d;
    logic         res_err_q, res_err_d;

    logic         accept_is_alu;
    logic [3:0]   alu_flags;

    assign accept_is_alu = (instr[13:10] <= OP_LAST_ALU);
    // Logic and shift ops never report overflow, whatever the ALU drives.
    assign alu_flags = {alu_zero, alu_negative, alu_carry,
                        alu_overflow & (op_q < OP_AND)};

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rd_d          = rd_q;
        imm_d         = imm_q;
        regs_d        = regs_q;
        flags_d       = flags_q;
        instr_ready_d = instr_ready_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opcode_d  = alu_opcode_q;
        alu_enable_d  = alu_enable_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_flags_d   = res_flags_q;
        res_err_d     = res_err_q;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d          = instr[13:10];
                    rd_d          = instr[9:8];
                    imm_d         = instr[3:0];
                    // ALU outputs are registered here so they are valid for the whole EXEC cycle.
                    alu_enable_d  = accept_is_alu;
                    alu_opcode_d  = accept_is_alu ? instr[13:10] : '0;
                    alu_a_d       = accept_is_alu ? regs_q[instr[7:6]] : '0;
                    alu_b_d       = accept_is_alu ? regs_q[instr[5:4]] : '0;
                    instr_ready_d = 1'b0;
                    state_d       = EXEC;
                end
            end
            EXEC: begin
                alu_enable_d = 1'b0;
                alu_opcode_d = '0;
                alu_a_d      = '0;
                alu_b_d      = '0;
                res_valid_d  = 1'b1;
                state_d      = RESP;
                if (op_q <= OP_LAST_ALU) begin
                    regs_d[rd_q] = alu_result;
                    flags_d      = alu_flags;
                    res_data_d   = alu_result;
                    res_flags_d  = alu_flags;
                    res_err_d    = 1'b0;
                end else if (op_q == OP_LDI) begin
                    regs_d[rd_q] = imm_q;
                    res_data_d   = imm_q;
                    res_flags_d  = {imm_q == '0, imm_q[W-1], 2'b00};
                    res_err_d    = 1'b0;
                end else begin
                    res_data_d  = '0;
                    res_flags_d = '0;
                    res_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d   = 1'b0;
                    instr_ready_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            op_q          <= '0;
            rd_q          <= '0;
            imm_q         <= '0;
            for (int unsigned i = 0; i < 4; i++) regs_q[i] <= '0;
            flags_q       <= '0;
            instr_ready_q <= 1'b1;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_opcode_q  <= '0;
            alu_enable_q  <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_flags_q   <= '0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            imm_q         <= imm_d;
            regs_q        <= regs_d;
            flags_q       <= flags_d;
            instr_ready_q <= instr_ready_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opcode_q  <= alu_opcode_d;
            alu_enable_q  <= alu_enable_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_flags_q   <= res_flags_d;
            res_err_q     <= res_err_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_enable  = alu_enable_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_flags   = res_flags_q;
    assign res_err     = res_err_q;

endmodule
